mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the address and data paths (only 32 is supported).
REQ-002 The block SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have port req_valid  in  1  EX stage issues a memory operation.
REQ-005 The block SHALL have port req_ready  out  1  unit can accept a request.
REQ-006 The block SHALL have port op  in  3  operation code: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-007 The block SHALL have port base  in  32  rs register value.
REQ-008 The block SHALL have port offset  in  32  sign-extended 16-bit immediate from the decode-stage extender.
REQ-009 The block SHALL have port wdata  in  32  rt value for stores.
REQ-010 The block SHALL have the SRAM-like bus ports data_req out 1, data_wr out 1, data_size out 2 (0 byte, 1 half, 2 word), data_addr out 32, data_wdata out 32, data_addr_ok in 1, data_data_ok in 1 and data_rdata in 32.
REQ-011 The block SHALL have port flush  in  1  pipeline flush (exception or eret).
REQ-012 The block SHALL have the response ports resp_valid out 1, resp_rdata out 32, exc_code out 2 (00 none, 01 AdEL, 10 AdES) and badvaddr out 32.

Function
REQ-013 Address: the unit SHALL compute addr = (base + offset) mod 2^32 on acceptance and register it, with no overflow trap.
REQ-014 Acceptance: a request SHALL be accepted on a cycle where req_valid=1, req_ready=1 and flush=0; req_ready SHALL be 1 only in state IDLE.
REQ-015 FSM states SHALL be IDLE, ADDR, DATA and RESP, with reset state IDLE.
REQ-016 IDLE -> ADDR SHALL occur on acceptance of an aligned request; IDLE -> RESP SHALL occur on acceptance of a misaligned request, with no bus activity.
REQ-017 Misalignment: LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL be misaligned; loads report exc_code=01 and stores report exc_code=10; badvaddr=addr.
REQ-018 In ADDR, data_req SHALL be 1 and data_addr, data_wr, data_size and data_wdata SHALL hold stable until data_addr_ok=1.
REQ-019 ADDR -> DATA SHALL occur on data_addr_ok=1 && data_data_ok=0; ADDR -> RESP SHALL occur when both are 1 in the same cycle.
REQ-020 DATA -> RESP SHALL occur on data_data_ok=1; data_req SHALL be 0 in DATA.
REQ-021 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-022 Store data: SB SHALL drive data_wdata={4{wdata[7:0]}}, SH SHALL drive {2{wdata[15:0]}}, SW SHALL drive wdata, and data_wr SHALL be 1 for stores.
REQ-023 Load data: data_rdata SHALL be captured when data_data_ok=1, then the byte/half selected by addr[1:0] is extracted.
REQ-024 LB/LH SHALL sign-extend the extracted value to 32 bits; LBU/LHU SHALL zero-extend it; LW SHALL pass the full word.
REQ-025 Store responses SHALL give resp_rdata=0.
REQ-026 Latency: the aligned path SHALL take a minimum of 2 cycles from acceptance to resp_valid (addr_ok and data_ok together on the first ADDR cycle); the misaligned path SHALL take exactly 1 cycle.
REQ-027 Flush in ADDR with data_addr_ok=0 SHALL abort to IDLE with no response.
REQ-028 Flush in ADDR with data_addr_ok=1, or flush in DATA, SHALL wait for data_data_ok, then go to IDLE with resp_valid held 0 (the transaction is discarded, the bus protocol is honoured).
REQ-029 Flush in RESP SHALL suppress resp_valid that cycle.
REQ-030 exc_code SHALL be 00 on every bus-completed response.

Reset
REQ-031 With resetn=0 at a clock edge, the state SHALL become IDLE and req_ready=1.
REQ-032 With resetn=0 at a clock edge, data_req, data_wr, resp_valid and exc_code SHALL be 0.
REQ-033 With resetn=0 at a clock edge, data_size, data_addr, data_wdata, resp_rdata and badvaddr SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding access, and any later data_data_ok for it SHALL be ignored.

Verification
REQ-035 The bench SHALL cover: LB base=0x1000, offset=0xFFFFFFFF, data_rdata=0x80FF1234 -> data_addr=0x00000FFF, data_size=0, resp_rdata=0xFFFFFF80.
REQ-036 The bench SHALL cover: LHU base=0x2000, offset=2, data_rdata=0xBEEF0000 -> resp_rdata=0x0000BEEF; the same with LH -> resp_rdata=0xFFFFBEEF.
REQ-037 The bench SHALL cover: SW base=0x3002, offset=0 -> no data_req, resp_valid 1 cycle after acceptance, exc_code=10, badvaddr=0x00003002.
REQ-038 The bench SHALL cover: SB wdata=0x000000A5, data_addr_ok=data_data_ok=1 on the first ADDR cycle -> data_wdata=0xA5A5A5A5, resp_valid 2 cycles after acceptance.
REQ-039 The bench SHALL cover: LW, flush asserted in DATA, data_data_ok 3 cycles later -> resp_valid stays 0, req_ready=1 the cycle after data_data_ok.
REQ-040 The bench SHALL cover: resetn=0 while in ADDR -> data_req=0 and state IDLE on the next edge, and a stale data_data_ok yields no response.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------------------------------------------------------------------
// Load/store unit sitting between the EX stage and an SRAM-like data bus.
// Accepts one memory operation at a time, computes the effective address
// (base + offset, wrapping), traps misaligned half/word accesses locally,
// drives an address/data two-phase bus handshake, and returns one response
// (sign/zero-extended load data or a store acknowledge).
//
// Ports
//   clk, resetn            clock; synchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   op                     000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW,
//                          101 SB, 110 SH, 111 SW
//   base, offset, wdata    rs value, sign-extended immediate, rt value
//   data_req/wr/size/addr/wdata      bus request (held stable until addr_ok)
//   data_addr_ok, data_data_ok, data_rdata   bus responses
//   flush                  pipeline flush; cancels/discards the operation
//   resp_valid, resp_rdata one-cycle response with load data (0 for stores)
//   exc_code, badvaddr     00 none, 01 AdEL, 10 AdES; faulting address
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [ADDR_W-1:0] data_rdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_rdata,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] badvaddr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  function automatic logic [1:0] op_size(input logic [2:0] o);
    logic [1:0] s;
    case (o)
      3'b000, 3'b001, 3'b101: s = 2'd0;
      3'b010, 3'b011, 3'b110: s = 2'd1;
      default:                s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic op_is_store(input logic [2:0] o);
    return o[2] & (o[1] | o[0]);
  endfunction

  // Registered state
  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
  // Set when a flush hit an access whose address phase already completed:
  // the data phase must still be absorbed, but its result is thrown away.
  logic              discard_q, discard_d;

  // Request-side decode
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_misaligned;
  logic              accept;
  logic [ADDR_W-1:0] req_wdata_rep;

  assign req_addr       = base + offset;
  assign req_size       = op_size(op);
  assign req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign accept         = (state_q == ST_IDLE) && req_valid && !flush;

  // Store data is replicated across all byte lanes so the bus slave can pick
  // the lane from the address without the unit shifting data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign req_wdata_rep[8*gi +: 8] =
        (req_size == 2'd0) ? wdata[7:0] :
        (req_size == 2'd1) ? wdata[8*(gi%2) +: 8] :
                             wdata[8*gi +: 8];
  end

  // Load extraction from the raw bus word using the registered address
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [ADDR_W-1:0] ld_value;

  always_comb begin
    ld_byte = data_rdata[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = data_rdata[7:0];
      2'd1: ld_byte = data_rdata[15:8];
      2'd2: ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {24'd0, ld_byte};
      3'b010:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_value = {16'd0, ld_half};
      3'b100:  ld_value = data_rdata;
      default: ld_value = '0;  // stores acknowledge with zero data
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    badvaddr_d = badvaddr_q;
    discard_d  = discard_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op;
          addr_d    = req_addr;
          wdata_d   = req_wdata_rep;
          rdata_d   = '0;
          discard_d = 1'b0;
          if (req_misaligned) begin
            // Trap locally: no bus traffic, respond next cycle.
            state_d    = ST_RESP;
            exc_d      = op_is_store(op) ? EXC_ADES : EXC_ADEL;
            badvaddr_d = req_addr;
          end else begin
            state_d    = ST_ADDR;
            exc_d      = EXC_NONE;
            badvaddr_d = '0;
          end
        end
      end

      ST_ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            rdata_d = ld_value;
            state_d = flush ? ST_IDLE : ST_RESP;
          end else begin
            state_d   = ST_DATA;
            discard_d = flush;
          end
        end else if (flush) begin
          // Address not yet taken by the bus: safe to drop outright.
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (data_data_ok) begin
          rdata_d   = ld_value;
          state_d   = (flush || discard_q) ? ST_IDLE : ST_RESP;
          discard_d = 1'b0;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end

      default: begin  // ST_RESP
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      exc_q      <= EXC_NONE;
      badvaddr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      exc_q      <= exc_d;
      badvaddr_q <= badvaddr_d;
      discard_q  <= discard_d;
    end
  end

  // Outputs
  assign req_ready  = (state_q == ST_IDLE);
  assign data_req   = (state_q == ST_ADDR);
  assign data_wr    = (state_q == ST_ADDR) && op_is_store(op_q);
  assign data_size  = op_size(op_q);
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  // A flush arriving in the response cycle kills the response.
  assign resp_valid = (state_q == ST_RESP) && !flush;
  assign resp_rdata = rdata_q;
  assign exc_code   = exc_q;
  assign badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vectors, scoreboard queues for
// expected bus requests and expected responses, checked by negedge monitors.
module tb_mem_access_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] base, offset, wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  exc_code;
  logic [31:0] badvaddr;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .base(base), .offset(offset), .wdata(wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_code(exc_code), .badvaddr(badvaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    logic [31:0] bva;
    int          at_cyc;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  // Monitors: bus request contents (checked every cycle data_req is up, so
  // stability is covered) and responses with their arrival cycle.
  bus_exp_t  be;
  resp_exp_t re;
  always @(negedge clk) begin
    if (resetn) begin
      if (data_req) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected got addr=%h exp no request", data_addr);
        end else begin
          be = bus_q[0];
          chk("bus_addr", data_addr, be.addr);
          chk("bus_wr",   {31'd0, data_wr}, {31'd0, be.wr});
          chk("bus_size", {30'd0, data_size}, {30'd0, be.size});
          if (be.wr) chk("bus_wdata", data_wdata, be.wdata);
          if (data_addr_ok) void'(bus_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected got rdata=%h exc=%0d exp no response", resp_rdata, exc_code);
        end else begin
          re = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, re.rdata);
          chk("resp_exc",   {30'd0, exc_code}, {30'd0, re.exc});
          if (re.exc != 2'b00) chk("resp_badvaddr", badvaddr, re.bva);
          chk("resp_cycle", cyc, re.at_cyc);
          $display("resp: rdata=%h exc=%0d badvaddr=%h cycle=%0d", resp_rdata, exc_code, badvaddr, cyc);
        end
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base, off, wdata, rdata;
    int          a, d;        // ADDR cycles before addr_ok; DATA cycles before data_ok
    bit          tog;         // addr_ok and data_ok in the same cycle
    logic [31:0] exp_rdata;
    logic [1:0]  exp_exc;
    logic [31:0] exp_bva, exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus_exp_t  b;
    resp_exp_t r;
    int        acc;
    bit        mis;
    mis = (v.exp_exc != 2'b00);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    if (!mis) begin
      b.addr = v.exp_addr; b.wr = v.op[2] & (v.op[1] | v.op[0]);
      b.size = v.exp_size; b.wdata = v.exp_wdata;
      bus_q.push_back(b);
    end
    req_valid = 1'b1; op = v.op; base = v.base; offset = v.off; wdata = v.wdata;
    acc = cyc;
    r.rdata = v.exp_rdata; r.exc = v.exp_exc; r.bva = v.exp_bva;
    r.at_cyc = mis ? acc + 1 : (v.tog ? acc + 2 + v.a : acc + 3 + v.a + v.d);
    resp_q.push_back(r);
    $display("req: op=%0d base=%h offset=%h wdata=%h accept_cycle=%0d", v.op, v.base, v.off, v.wdata, acc);
    step();
    req_valid = 1'b0;
    if (mis) begin
      chk("mis_no_data_req", {31'd0, data_req}, 32'd0);
    end else begin
      for (int i = 0; i < v.a; i++) step();
      data_addr_ok = 1'b1;
      if (v.tog) begin data_data_ok = 1'b1; data_rdata = v.rdata; end
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (!v.tog) begin
        for (int i = 0; i < v.d; i++) step();
        data_data_ok = 1'b1; data_rdata = v.rdata;
        step();
        data_data_ok = 1'b0;
      end
    end
    step();  // leave the response cycle
  endtask

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] wd);
    bus_exp_t b;
    b.addr = a; b.wr = w; b.size = s; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] b, input logic [31:0] off);
    req_valid = 1'b1; op = o; base = b; offset = off; wdata = 32'd0;
    $display("req: op=%0d base=%h offset=%h accept_cycle=%0d", o, b, off, cyc);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    //            op      base          off           wdata         rdata        a  d  tog exp_rdata     exc    bva           addr          sz    wdata
    vecs[0]  = '{3'b000, 32'h00001000, 32'hFFFFFFFF, 32'h00000000, 32'h80FF1234, 1, 1, 0, 32'hFFFFFF80, 2'b00, 32'h0,        32'h00000FFF, 2'd0, 32'h0};
    vecs[1]  = '{3'b011, 32'h00002000, 32'h00000002, 32'h00000000, 32'hBEEF0000, 0, 0, 1, 32'h0000BEEF, 2'b00, 32'h0,        32'h00002002, 2'd1, 32'h0};
    vecs[2]  = '{3'b010, 32'h00002000, 32'h00000002, 32'h00000000, 32'hBEEF0000, 0, 2, 0, 32'hFFFFBEEF, 2'b00, 32'h0,        32'h00002002, 2'd1, 32'h0};
    vecs[3]  = '{3'b111, 32'h00003002, 32'h00000000, 32'h11223344, 32'h0,        0, 0, 0, 32'h00000000, 2'b10, 32'h00003002, 32'h0,        2'd2, 32'h0};
    vecs[4]  = '{3'b101, 32'h00004000, 32'h00000001, 32'h000000A5, 32'h0,        0, 0, 1, 32'h00000000, 2'b00, 32'h0,        32'h00004001, 2'd0, 32'hA5A5A5A5};
    vecs[5]  = '{3'b100, 32'h00005000, 32'h00000004, 32'h00000000, 32'hDEADBEEF, 2, 0, 0, 32'hDEADBEEF, 2'b00, 32'h0,        32'h00005004, 2'd2, 32'h0};
    vecs[6]  = '{3'b100, 32'h00006001, 32'h00000000, 32'h00000000, 32'h0,        0, 0, 0, 32'h00000000, 2'b01, 32'h00006001, 32'h0,        2'd2, 32'h0};
    vecs[7]  = '{3'b010, 32'h00007000, 32'h00000003, 32'h00000000, 32'h0,        0, 0, 0, 32'h00000000, 2'b01, 32'h00007003, 32'h0,        2'd1, 32'h0};
    vecs[8]  = '{3'b110, 32'h00008000, 32'hFFFFFFFE, 32'h1234ABCD, 32'h0,        0, 0, 1, 32'h00000000, 2'b00, 32'h0,        32'h00007FFE, 2'd1, 32'hABCDABCD};
    vecs[9]  = '{3'b001, 32'h00009000, 32'h00000002, 32'h00000000, 32'h00C30000, 0, 1, 0, 32'h000000C3, 2'b00, 32'h0,        32'h00009002, 2'd0, 32'h0};
    vecs[10] = '{3'b000, 32'h00009000, 32'h00000001, 32'h00000000, 32'h00007F00, 0, 0, 1, 32'h0000007F, 2'b00, 32'h0,        32'h00009001, 2'd0, 32'h0};
    vecs[11] = '{3'b110, 32'h0000A001, 32'h00000000, 32'h0000FFFF, 32'h0,        0, 0, 0, 32'h00000000, 2'b10, 32'h0000A001, 32'h0,        2'd1, 32'h0};
    vecs[12] = '{3'b100, 32'hFFFFFFFC, 32'h00000008, 32'h00000000, 32'h12345678, 0, 0, 1, 32'h12345678, 2'b00, 32'h0,        32'h00000004, 2'd2, 32'h0};
    vecs[13] = '{3'b101, 32'h0000B003, 32'h00000000, 32'hFFFFFF5A, 32'h0,        1, 0, 0, 32'h00000000, 2'b00, 32'h0,        32'h0000B003, 2'd0, 32'h5A5A5A5A};

    resetn = 1'b0; req_valid = 1'b0; op = 3'd0; base = '0; offset = '0; wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; flush = 1'b0;
    step(); step();

    // Reset state
    chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_data_req",   {31'd0, data_req}, 32'd0);
    chk("rst_data_wr",    {31'd0, data_wr}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_exc_code",   {30'd0, exc_code}, 32'd0);
    chk("rst_data_size",  {30'd0, data_size}, 32'd0);
    chk("rst_data_addr",  data_addr, 32'd0);
    chk("rst_data_wdata", data_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_badvaddr",   badvaddr, 32'd0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Flush while idle blocks acceptance
    req_valid = 1'b1; op = 3'b100; base = 32'h100; offset = 32'h0; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept", {31'd0, req_ready}, 32'd1);
    step();
    chk("flush_idle_no_req", {31'd0, data_req}, 32'd0);

    // Flush in ADDR before addr_ok: abort, no response
    push_bus(32'h0000E000, 1'b0, 2'd2, 32'h0);
    issue(3'b100, 32'h0000E000, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_addr_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_addr_noreq", {31'd0, data_req}, 32'd0);
    bus_q.delete();
    step();

    // Flush in ADDR together with addr_ok: drain data phase, no response
    push_bus(32'h0000E100, 1'b0, 2'd2, 32'h0);
    issue(3'b100, 32'h0000E100, 32'h0);
    flush = 1'b1; data_addr_ok = 1'b1;
    step();
    flush = 1'b0; data_addr_ok = 1'b0;
    chk("flush_addrok_busy", {31'd0, req_ready}, 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    step();
    data_data_ok = 1'b0;
    chk("flush_addrok_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_addrok_noresp", {31'd0, resp_valid}, 32'd0);
    step();

    // LW, flush in DATA, data_ok three cycles later
    push_bus(32'h0000C000, 1'b0, 2'd2, 32'h0);
    issue(3'b100, 32'h0000C000, 32'h0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_data_wait_busy", {31'd0, req_ready}, 32'd0);
      chk("flush_data_wait_noresp", {31'd0, resp_valid}, 32'd0);
      step();
    end
    data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    step();
    data_data_ok = 1'b0;
    chk("flush_data_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_data_noresp", {31'd0, resp_valid}, 32'd0);
    step();
    chk("flush_data_noresp2", {31'd0, resp_valid}, 32'd0);

    // Flush during the response cycle suppresses it
    issue(3'b100, 32'h0000F002, 32'h0);
    flush = 1'b1;
    #2;
    chk("flush_resp_suppressed", {31'd0, resp_valid}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_resp_ready", {31'd0, req_ready}, 32'd1);

    // Reset while in ADDR; stale data_ok afterwards is ignored
    push_bus(32'h0000D000, 1'b0, 2'd2, 32'h0);
    issue(3'b100, 32'h0000D000, 32'h0);
    chk("rst_mid_in_addr", {31'd0, data_req}, 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    bus_q.delete();
    chk("rst_mid_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h0BADBAD0;
    step();
    data_data_ok = 1'b0;
    chk("rst_mid_stale_noresp", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_stale_ready", {31'd0, req_ready}, 32'd1);
    step();

    // A normal access still works after all of the above
    run_vec(vecs[0]);
    step(); step();

    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("bus_queue_drained", bus_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
